// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II multi-cycle multiply sequencer and its
// high-word combiner.
package nios2_mult_pkg;

  localparam int unsigned CELL_W = 32;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    CAP1,
    WAIT2,
    CAP2,
    RESP
  } state_t;

endpackage

// File: rtl/nios2_mult_hi_combine.sv
// Combines the four 16x16 partial products into the high 32 bits of the
// 64-bit product, applying two's-complement corrections for signed operands.
module nios2_mult_hi_combine
  import nios2_mult_pkg::*;
(
  input  logic [CELL_W-1:0] p1,
  input  logic [CELL_W-1:0] p2,
  input  logic [CELL_W-1:0] p3,
  input  logic [CELL_W-1:0] p4,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic [1:0]        op,
  output logic [31:0]       hi
);

  logic [17:0] mid;
  logic [31:0] hu;

  always_comb begin
    mid = {2'b00, p1[31:16]} + {2'b00, p2[15:0]} + {2'b00, p3[15:0]};
    hu  = p4 + {16'h0, p2[31:16]} + {16'h0, p3[31:16]} + {30'h0, mid[17:16]};
    hi  = hu;
    // A negative operand contributes -2^32 * other operand to the product.
    if ((op == OP_MULXSU || op == OP_MULXSS) && a[31]) hi = hi - b;
    if (op == OP_MULXSS && b[31]) hi = hi - a;
  end

endmodule

// File: rtl/nios2_mult_sequencer.sv
// Drives one or two passes through the shared 16x16 partial-product cell and
// returns the low (MUL) or high (MULX*) product word over a valid/ready pair.
module nios2_mult_sequencer
  import nios2_mult_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [31:0]       cell_src1,
  output logic [31:0]       cell_src2,
  output logic              cell_en,
  input  logic [CELL_W-1:0] cell_p1,
  input  logic [CELL_W-1:0] cell_p2,
  input  logic [CELL_W-1:0] cell_p3
);

  localparam bit         NO_WAIT   = (CELL_LATENCY == 1);
  localparam logic [1:0] WAIT_INIT = 2'((CELL_LATENCY > 1) ? (CELL_LATENCY - 2) : 0);

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] p1_q, p2_q, p3_q;
  logic [1:0]  wait_cnt;
  logic [31:0] lo_word, hi_word;
  logic        enter_cap1;

  assign req_ready  = (state == IDLE);
  assign lo_word    = cell_p1 + {cell_p2[15:0], 16'h0} + {cell_p3[15:0], 16'h0};
  assign enter_cap1 = (state == ISSUE1 && NO_WAIT) || (state == WAIT1 && wait_cnt == 2'd0);

  nios2_mult_hi_combine u_hi_combine (
    .p1 (p1_q),
    .p2 (p2_q),
    .p3 (p3_q),
    .p4 (cell_p1),
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .hi (hi_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cell_en   <= 1'b0;
      cell_src1 <= '0;
      cell_src2 <= '0;
    end else begin
      cell_en <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          op_q      <= req_op;
          a_q       <= req_a;
          b_q       <= req_b;
          cell_src1 <= req_a;
          cell_src2 <= req_b;
          cell_en   <= 1'b1;
          state     <= ISSUE1;
        end
        ISSUE1: begin
          wait_cnt <= WAIT_INIT;
          state    <= NO_WAIT ? CAP1 : WAIT1;
        end
        WAIT1: begin
          if (wait_cnt == 2'd0) state <= CAP1;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        CAP1: begin
          if (op_q == OP_MUL) begin
            rsp_data  <= lo_word;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            p1_q     <= cell_p1;
            p2_q     <= cell_p2;
            p3_q     <= cell_p3;
            wait_cnt <= WAIT_INIT;
            state    <= NO_WAIT ? CAP2 : WAIT2;
          end
        end
        WAIT2: begin
          if (wait_cnt == 2'd0) state <= CAP2;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        CAP2: begin
          rsp_data  <= hi_word;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Outputs are registered, so the second-pass issue is loaded on the
      // edge that enters CAP1 and is therefore presented during CAP1.
      if (enter_cap1 && op_q != OP_MUL) begin
        cell_src1 <= {16'h0, a_q[31:16]};
        cell_src2 <= {16'h0, b_q[31:16]};
        cell_en   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios2_mult_sequencer.sv
// Bench for nios2_mult_sequencer: three instances (cell latency 1, 2, 3), each
// with its own behavioural multiplier cell, checked against a 64-bit product.
module tb_nios2_mult_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [N];
  logic        rv     [N];
  logic [1:0]  rop    [N];
  logic [31:0] ra     [N];
  logic [31:0] rb     [N];
  logic        sready [N];
  logic        rq_ready [N];
  logic        sv     [N];
  logic [31:0] sdata  [N];
  logic        cen    [N];

  int n_pass  = 0;
  int n_total = 0;

  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int unsigned L = k + 1;
    logic        l_req_ready, l_rsp_valid, l_cell_en;
    logic [31:0] l_rsp_data, l_src1, l_src2;
    logic [31:0] cp1, cp2, cp3;
    logic [31:0] prod1, prod2, prod3;
    logic [3:0]  en_sr;
    logic [31:0] s1 [4];
    logic [31:0] s2 [4];
    logic [31:0] s3 [4];

    nios2_mult_sequencer #(.CELL_LATENCY(L)) dut (
      .clk       (clk),
      .reset     (rst[k]),
      .req_valid (rv[k]),
      .req_ready (l_req_ready),
      .req_op    (rop[k]),
      .req_a     (ra[k]),
      .req_b     (rb[k]),
      .rsp_valid (l_rsp_valid),
      .rsp_ready (sready[k]),
      .rsp_data  (l_rsp_data),
      .cell_src1 (l_src1),
      .cell_src2 (l_src2),
      .cell_en   (l_cell_en),
      .cell_p1   (cp1),
      .cell_p2   (cp2),
      .cell_p3   (cp3)
    );

    assign rq_ready[k] = l_req_ready;
    assign sv[k]       = l_rsp_valid;
    assign sdata[k]    = l_rsp_data;
    assign cen[k]      = l_cell_en;

    assign prod1 = {16'h0, l_src1[15:0]}  * {16'h0, l_src2[15:0]};
    assign prod2 = {16'h0, l_src1[15:0]}  * {16'h0, l_src2[31:16]};
    assign prod3 = {16'h0, l_src1[31:16]} * {16'h0, l_src2[15:0]};

    always @(posedge clk) begin
      if (rst[k]) en_sr <= '0;
      else        en_sr <= {en_sr[2:0], l_cell_en};
      s1[0] <= prod1;
      s2[0] <= prod2;
      s3[0] <= prod3;
      for (int i = 1; i < 4; i++) begin
        s1[i] <= s1[i-1];
        s2[i] <= s2[i-1];
        s3[i] <= s3[i-1];
      end
    end

    if (L == 1) begin : g_l1
      always @(posedge clk) if (l_cell_en) begin
        cp1 <= prod1; cp2 <= prod2; cp3 <= prod3;
      end
    end else begin : g_ln
      always @(posedge clk) if (en_sr[L-2]) begin
        cp1 <= s1[L-2]; cp2 <= s2[L-2]; cp3 <= s3[L-2];
      end
    end
  end

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'd3) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
      2:       return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold,
                        input bit present_next, input logic [1:0] nop,
                        input logic [31:0] na, input logic [31:0] nb);
    int cyc, pulses, lat_exp;
    logic [31:0] d0;
    cyc = 0;
    while (!rq_ready[k] && cyc < 50) begin tick(); cyc++; end
    check("req_ready_before_issue", 32'(rq_ready[k]), 32'd1);
    rop[k] = op; ra[k] = a; rb[k] = b; rv[k] = 1'b1;
    tick();
    rv[k] = 1'b0;
    cyc = 1; pulses = 0;
    while (!sv[k] && cyc < 60) begin
      pulses += int'(cen[k]);
      tick();
      cyc++;
    end
    lat_exp = (op == 2'd0) ? 2 + (k + 1) : 2 + 2 * (k + 1);
    check("rsp_latency", 32'(cyc), 32'(lat_exp));
    check("cell_en_pulses", 32'(pulses), (op == 2'd0) ? 32'd1 : 32'd2);
    check("rsp_data", sdata[k], exp);
    d0 = sdata[k];
    if (present_next) begin
      rop[k] = nop; ra[k] = na; rb[k] = nb; rv[k] = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_rsp_valid", 32'(sv[k]), 32'd1);
      check("hold_rsp_data", sdata[k], d0);
      check("hold_req_ready", 32'(rq_ready[k]), 32'd0);
      check("hold_cell_en", 32'(cen[k]), 32'd0);
    end
    sready[k] = 1'b1;
    tick();
    sready[k] = 1'b0;
    check("post_rsp_valid", 32'(sv[k]), 32'd0);
    check("post_req_ready", 32'(rq_ready[k]), 32'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; rv[k] = 1'b0; rop[k] = '0; ra[k] = '0; rb[k] = '0; sready[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    tick();
    check("reset_req_ready", 32'(rq_ready[0]), 32'd1);
    check("reset_rsp_valid", 32'(sv[0]), 32'd0);
    check("reset_rsp_data", sdata[0], 32'd0);
    check("reset_cell_en", 32'(cen[0]), 32'd0);
    check("reset_cell_src1", g_inst[0].l_src1, 32'd0);
    check("reset_cell_src2", g_inst[0].l_src2, 32'd0);

    // Directed cases, latency 1
    run_op(0, 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, 0, 2'd0, 0, 0);
    run_op(0, 2'd1, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 0, 0, 2'd0, 0, 0);
    run_op(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 2'd0, 0, 0);
    run_op(0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 2'd0, 0, 0);
    run_op(0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 0);
    run_op(0, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 2'd0, 0, 0);

    // Backpressure with a waiting request, then that request runs to completion
    run_op(0, 2'd3, 32'h1234_5678, 32'h8765_4321, ref_mul(2'd3, 32'h1234_5678, 32'h8765_4321),
           7, 1, 2'd0, 32'h0000_FFFF, 32'h0001_0001);
    run_op(0, 2'd0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 0);

    // Reset in WAIT2 (d=4) and CAP2 (d=5) with latency 2
    for (int d = 4; d <= 5; d++) begin
      rop[1] = 2'd1; ra[1] = 32'hDEAD_BEEF; rb[1] = 32'hCAFE_F00D; rv[1] = 1'b1;
      tick();
      rv[1] = 1'b0;
      for (int i = 1; i < d; i++) tick();
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      check("abort_rsp_valid", 32'(sv[1]), 32'd0);
      check("abort_cell_en", 32'(cen[1]), 32'd0);
      check("abort_req_ready", 32'(rq_ready[1]), 32'd1);
      for (int i = 0; i < 5; i++) begin
        tick();
        check("abort_quiet", {30'h0, sv[1], cen[1]}, 32'd0);
      end
      run_op(1, 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, 0, 2'd0, 0, 0);
    end

    // Random operations against the 64-bit reference, latencies 1 and 3
    for (int k = 0; k < N; k += 2) begin
      for (int i = 0; i < 40; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = pick_operand();
        b  = pick_operand();
        run_op(k, op, a, b, ref_mul(op, a, b), int'($urandom_range(0, 3)), 0, 2'd0, 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nios2_mult_sequencer.md
# nios2_mult_sequencer

Multi-cycle controller that drives the shared three-partial-product 16x16 multiplier cell (outputs p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo, registered one cycle after an enabled issue). It accepts one multiply request at a time through a valid/ready handshake. It sequences one or two passes through the cell, combines the partial products into a 32-bit low or high product word, and holds the result until the consumer accepts it. It sits between the Nios II execute stage and the multiplier cell.

## Interface
- CELL_LATENCY, 1, cycles from an issue with cell_en=1 to valid cell_p1..p3; legal values 1..4.
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; equals state==IDLE.
- req_op  in  2  operation: 0 MUL (low 32 bits), 1 MULXUU, 2 MULXSU (a signed, b unsigned), 3 MULXSS; ops 1..3 return the high 32 bits.
- req_a, req_b  in  32  operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  result word.
- cell_src1, cell_src2  out  32  operands driven to the cell.
- cell_en  out  1  cell register enable.
- cell_p1, cell_p2, cell_p3  in  32  partial products from the cell.

## Operation
- States and transitions:
  - IDLE: a handshake (req_valid & req_ready) latches op, a and b, then goes to ISSUE1.
  - ISSUE1: cell_src1=a, cell_src2=b, cell_en=1, then go to WAIT1.
  - WAIT1: counts CELL_LATENCY-1 cycles; it is skipped when CELL_LATENCY=1. Then go to CAP1.
  - CAP1: capture cell_p1..p3.
    - MUL: rsp_data <= p1 + (p2<<16) + (p3<<16), mod 2^32, then go to RESP.
    - MULX: issue the second pass in the same cycle with cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1, then go to WAIT2.
  - WAIT2: same count rule as WAIT1, then go to CAP2.
  - CAP2: p4 = cell_p1.
    - mid = p1[31:16] + p2[15:0] + p3[15:0], 18 bits.
    - hu = p4 + p2[31:16] + p3[31:16] + mid[17:16], mod 2^32.
    - MULXUU: rsp_data <= hu.
    - MULXSU: rsp_data <= hu - (a[31] ? b : 0).
    - MULXSS: rsp_data <= hu - (a[31] ? b : 0) - (b[31] ? a : 0).
    - Then go to RESP.
  - RESP: rsp_valid=1; on rsp_ready go to IDLE.
- cell_en is 0 in every state not listed above as issuing; the cell then holds its outputs.
- cell_src1/src2 keep their last driven value when not issuing.
- rsp_data and rsp_valid stay stable while rsp_ready=0, for any number of cycles.
- Requests arriving while req_ready=0 are ignored; the requester must hold them.
- Reset values: state IDLE, req_ready=1 in the following cycle, rsp_valid=0, rsp_data=0, cell_en=0, cell_src1=cell_src2=0.
- Reset asserted mid-operation aborts the operation: no response and no later cell_en. The cell contents are don't-care.

## Timing
- Handshake at cycle t with CELL_LATENCY=1:
  - MUL: ISSUE1 in t+1, CAP1 in t+2, rsp_valid in t+3.
  - MULX: CAP1/second issue in t+2, CAP2 in t+3, rsp_valid in t+4.
- Each additional CELL_LATENCY cycle adds 1 cycle per pass.
- If rsp_ready is high in the first RESP cycle, req_ready rises the next cycle. Back-to-back MUL throughput is one result per 4 cycles.
- No combinational path from rsp_ready or req_valid to cell_en.

## Structure
- Shared package nios2_mult_pkg:
  - op encoding constants OP_MUL/OP_MULXUU/OP_MULXSU/OP_MULXSS.
  - state enum.
  - cell partial-product width constant (32).
- One sub-module, nios2_mult_hi_combine: combinational; inputs p1..p4, a, b, op; output is the high word including signed corrections.
- The FSM, wait counter, operand/partial registers and low-word adder are in the top module.

## Test plan
- MUL a=0x00010003, b=0x00020005 -> rsp_data=0x000B000F, rsp_valid exactly 3 cycles after the handshake, single cell_en pulse.
- MULXUU a=0x00010003, b=0x00020005 -> 0x00000002; MULXUU a=b=0xFFFFFFFF -> 0xFFFFFFFE; exactly two cell_en pulses, rsp_valid at t+4.
- MULXSS a=b=0xFFFFFFFF -> 0x00000000; MULXSU a=b=0xFFFFFFFF -> 0xFFFFFFFF; MULXSS a=0x80000000, b=0x80000000 -> 0x40000000.
- Backpressure: rsp_ready low for 7 cycles -> rsp_data/rsp_valid stable, req_ready=0, cell_en=0 throughout; a request presented meanwhile is accepted only after the response handshake.
- Reset in WAIT2/CAP2 (CELL_LATENCY=2) -> next cycle rsp_valid=0, cell_en=0, req_ready=1; the next MUL completes correctly.
- Randomized op/operands against a 64-bit reference model (signed/unsigned), CELL_LATENCY 1 and 3, with random rsp_ready.
